// File: rtl/dice_pkg.sv
// Shared constants, FSM state type and face-legality check for the dice round judge.
package dice_pkg;

   localparam logic [1:0] PAT_DIGIT = 2'd0;
   localparam logic [1:0] PAT_ALL   = 2'd1;
   localparam logic [1:0] PAT_HBAR  = 2'd2;
   localparam logic [1:0] PAT_MID   = 2'd3;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_EVAL    = 2'd1,
      ST_RESULT  = 2'd2
   } state_t;

   function automatic logic face_legal(input logic [31:0] face, input logic [31:0] max_face);
      return (face != 32'd0) && (face <= max_face);
   endfunction

endpackage

// File: rtl/dice_classifier.sv
// Combinational round classifier: pasch detection plus display pattern selection.
module dice_classifier
   import dice_pkg::*;
#(
   parameter int N_PLAYERS = 2,
   parameter int DICE_W    = 3
) (
   input  logic [N_PLAYERS*DICE_W-1:0] vals,
   output logic                        pasch,
   output logic [DICE_W-1:0]           face,
   output logic [1:0]                  pattern
);

   logic has1;
   logic has2;
   logic has3;

   always_comb begin
      pasch = 1'b1;
      has1  = 1'b0;
      has2  = 1'b0;
      has3  = 1'b0;
      face  = vals[DICE_W-1:0];
      for (int p = 0; p < N_PLAYERS; p++) begin
         if (vals[p*DICE_W +: DICE_W] != face)            pasch = 1'b0;
         if (vals[p*DICE_W +: DICE_W] == DICE_W'(1))      has1  = 1'b1;
         if (vals[p*DICE_W +: DICE_W] == DICE_W'(2))      has2  = 1'b1;
         if (vals[p*DICE_W +: DICE_W] == DICE_W'(3))      has3  = 1'b1;
      end
      // Priority order: pasch, then 1-and-2 combination, then any three.
      if (pasch)            pattern = PAT_DIGIT;
      else if (has1 && has2) pattern = PAT_ALL;
      else if (has3)        pattern = PAT_HBAR;
      else                  pattern = PAT_MID;
   end

endmodule

// File: rtl/dice_round_judge.sv
// Round evaluator: latches one roll per player, classifies the round and offers
// the result to the display stage; supports clear, optional timeout and statistics.
module dice_round_judge
   import dice_pkg::*;
#(
   parameter int N_PLAYERS = 2,
   parameter int DICE_W    = 3,
   parameter int MAX_FACE  = 6,
   parameter int TIMEOUT   = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_PLAYERS*DICE_W-1:0] dice,
   input  logic [N_PLAYERS-1:0]        rolled,
   input  logic                        clear,
   input  logic                        result_ready,
   output logic                        result_valid,
   output logic [3:0]                  digit,
   output logic [1:0]                  pattern,
   output logic                        timed_out,
   output logic [7:0]                  round_count,
   output logic [7:0]                  pasch_count,
   output logic [1:0]                  state_dbg
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t                      state, state_d;
   logic [N_PLAYERS-1:0]        got, got_d, got_next, accept, load;
   logic [N_PLAYERS*DICE_W-1:0] slot_q;
   logic [TW-1:0]               timer, timer_d;
   logic                        complete, timeout_hit;
   logic                        abort, timeout_abort, do_eval;
   logic                        cls_pasch;
   logic [DICE_W-1:0]           cls_face;
   logic [1:0]                  cls_pattern;

   dice_classifier #(
      .N_PLAYERS (N_PLAYERS),
      .DICE_W    (DICE_W)
   ) u_classifier (
      .vals    (slot_q),
      .pasch   (cls_pasch),
      .face    (cls_face),
      .pattern (cls_pattern)
   );

   // Handshake: result_valid is asserted in RESULT and held until an edge with
   // result_ready high completes the transfer; clear drops the pending result.
   assign result_valid = (state == ST_RESULT);
   assign state_dbg    = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_COLLECT;
      else        state <= state_d;
   end

   always_comb begin
      accept = '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         if (rolled[p] && !got[p] &&
             face_legal(32'(dice[p*DICE_W +: DICE_W]), 32'(MAX_FACE)))
            accept[p] = 1'b1;
      end
      got_next = got | accept;
      complete = &got_next;
      // The timer reaches TIMEOUT on the edge where it would step to that value.
      timeout_hit = (TIMEOUT > 0) && (|got) && (timer == TW'(TIMEOUT - 1));

      state_d       = state;
      got_d         = got;
      timer_d       = timer;
      load          = '0;
      abort         = 1'b0;
      timeout_abort = 1'b0;
      do_eval       = 1'b0;

      case (state)
         ST_COLLECT: begin
            if (clear) begin
               abort = 1'b1;
            end else if (&got) begin
               state_d = ST_EVAL;
            end else if (timeout_hit && !complete) begin
               abort         = 1'b1;
               timeout_abort = 1'b1;
            end else begin
               got_d   = got_next;
               load    = accept;
               timer_d = (|got) ? timer + TW'(1) : '0;
            end
         end
         ST_EVAL: begin
            do_eval = 1'b1;
            state_d = ST_RESULT;
         end
         ST_RESULT: begin
            if (clear) begin
               abort   = 1'b1;
               state_d = ST_COLLECT;
            end else if (result_ready) begin
               state_d = ST_COLLECT;
               got_d   = '0;
               timer_d = '0;
            end
         end
         default: state_d = ST_COLLECT;
      endcase

      if (abort) begin
         got_d   = '0;
         timer_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         got         <= '0;
         slot_q      <= '0;
         timer       <= '0;
         digit       <= 4'd0;
         pattern     <= PAT_MID;
         timed_out   <= 1'b0;
         round_count <= 8'd0;
         pasch_count <= 8'd0;
      end else begin
         got       <= got_d;
         timer     <= timer_d;
         timed_out <= timeout_abort;
         for (int p = 0; p < N_PLAYERS; p++) begin
            if (load[p]) slot_q[p*DICE_W +: DICE_W] <= dice[p*DICE_W +: DICE_W];
         end
         if (abort) pattern <= PAT_MID;
         if (do_eval) begin
            round_count <= round_count + 8'd1;
            pattern     <= cls_pattern;
            if (cls_pasch) begin
               digit <= 4'(cls_face);
               if (pasch_count != 8'hFF) pasch_count <= pasch_count + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dice_round_judge.sv
// Self-checking bench for dice_round_judge (3 players, timeout 10) with a round-level model.
module tb_dice_round_judge;

   localparam int NP = 3;
   localparam int DW = 3;
   localparam int MF = 6;
   localparam int TO = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NP*DW-1:0] dice = '0;
   logic [NP-1:0] rolled = '0;
   logic          clear = 1'b0;
   logic          result_ready = 1'b0;
   logic          result_valid;
   logic [3:0]    digit;
   logic [1:0]    pattern;
   logic          timed_out;
   logic [7:0]    round_count;
   logic [7:0]    pasch_count;
   logic [1:0]    state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int to_pulses = 0;

   logic [5:0] exp_q[$];
   int         exp_round = 0;
   int         exp_pasch = 0;
   logic [3:0] exp_digit = 4'd0;

   dice_round_judge #(
      .N_PLAYERS (NP),
      .DICE_W    (DW),
      .MAX_FACE  (MF),
      .TIMEOUT   (TO)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dice         (dice),
      .rolled       (rolled),
      .clear        (clear),
      .result_ready (result_ready),
      .result_valid (result_valid),
      .digit        (digit),
      .pattern      (pattern),
      .timed_out    (timed_out),
      .round_count  (round_count),
      .pasch_count  (pasch_count),
      .state_dbg    (state_dbg)
   );

   // Clock and timeout pulse monitor
   always #5 clk = ~clk;
   always @(negedge clk) if (timed_out === 1'b1) to_pulses++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic void model_round(input int a, input int b, input int c);
      logic [1:0] pat;
      if (a == b && b == c) begin
         pat = 2'd0;
         exp_digit = 4'(a);
         if (exp_pasch < 255) exp_pasch++;
      end else if ((a == 1 || b == 1 || c == 1) && (a == 2 || b == 2 || c == 2)) pat = 2'd1;
      else if (a == 3 || b == 3 || c == 3) pat = 2'd2;
      else pat = 2'd3;
      exp_round = (exp_round + 1) % 256;
      exp_q.push_back({exp_digit, pat});
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      exp_round = 0;
      exp_pasch = 0;
      exp_digit = 4'd0;
   endfunction

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rolls(input logic [NP-1:0] mask, input int f0, input int f1, input int f2);
      dice   = {3'(f2), 3'(f1), 3'(f0)};
      rolled = mask;
      tick();
      rolled = '0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (result_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic handshake();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", result_valid); end
      n_checks++; if (digit !== 4'd0) begin n_fail++; $display("FAIL reset_digit: got %0d want 0", digit); end
      n_checks++; if (pattern !== 2'd3) begin n_fail++; $display("FAIL reset_pattern: got %0d want 3", pattern); end
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL reset_timed_out: got %0b want 0", timed_out); end
      n_checks++; if (round_count !== 8'd0 || pasch_count !== 8'd0) begin
         n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", round_count, pasch_count); end
   endtask

   task automatic test_pasch();
      logic [5:0] e;
      int n;
      drive_rolls(3'b111, 4, 4, 4);
      model_round(4, 4, 4);
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL pasch_lat1: got %0b want 0", result_valid); end
      tick();
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL pasch_lat2: got %0b want 0", result_valid); end
      tick();
      n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL pasch_valid: got %0b want 1", result_valid); end
      e = exp_q.pop_front();
      n_checks++; if ({digit, pattern} !== e) begin
         n_fail++; $display("FAIL pasch_result: got d%0d p%0d want d%0d p%0d", digit, pattern, e[5:2], e[1:0]); end
      n_checks++; if (pasch_count !== 8'(exp_pasch) || round_count !== 8'(exp_round)) begin
         n_fail++; $display("FAIL pasch_counts: got %0d/%0d want %0d/%0d", pasch_count, round_count, exp_pasch, exp_round); end
      handshake();
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL pasch_hs: got %0b want 0", result_valid); end
      n_checks++; if ({digit, pattern} !== e) begin
         n_fail++; $display("FAIL pasch_persist: got d%0d p%0d want d%0d p%0d", digit, pattern, e[5:2], e[1:0]); end
      drive_rolls(3'b111, 2, 5, 6);
      model_round(2, 5, 6);
      wait_valid(n);
      n_checks++; if (n != 2) begin n_fail++; $display("FAIL nonpasch_latency: got %0d want 2", n); end
      e = exp_q.pop_front();
      n_checks++; if ({digit, pattern} !== e) begin
         n_fail++; $display("FAIL nonpasch_result: got d%0d p%0d want d%0d p%0d", digit, pattern, e[5:2], e[1:0]); end
      handshake();
   endtask

   task automatic test_classes();
      int tbl[5][3] = '{'{2, 6, 1}, '{5, 3, 5}, '{1, 1, 2}, '{3, 4, 4}, '{6, 5, 4}};
      logic [5:0] e;
      int n;
      for (int i = 0; i < 5; i++) begin
         drive_rolls(3'b111, tbl[i][0], tbl[i][1], tbl[i][2]);
         model_round(tbl[i][0], tbl[i][1], tbl[i][2]);
         wait_valid(n);
         e = exp_q.pop_front();
         n_checks++; if (result_valid !== 1'b1 || {digit, pattern} !== e) begin
            n_fail++; $display("FAIL class_%0d: got v%0b d%0d p%0d want v1 d%0d p%0d", i, result_valid, digit, pattern, e[5:2], e[1:0]); end
         n_checks++; if (round_count !== 8'(exp_round)) begin
            n_fail++; $display("FAIL class_rounds_%0d: got %0d want %0d", i, round_count, exp_round); end
         handshake();
      end
   endtask

   task automatic test_ignore();
      logic [5:0] e;
      int n;
      drive_rolls(3'b001, 3, 0, 0);
      drive_rolls(3'b001, 6, 0, 0);
      drive_rolls(3'b010, 0, 7, 0);
      drive_rolls(3'b100, 0, 0, 6);
      drive_rolls(3'b010, 0, 0, 0);
      tick();
      tick();
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL ignore_illegal: got %0b want 0", result_valid); end
      drive_rolls(3'b010, 0, 6, 0);
      model_round(3, 6, 6);
      wait_valid(n);
      e = exp_q.pop_front();
      n_checks++; if (result_valid !== 1'b1 || {digit, pattern} !== e) begin
         n_fail++; $display("FAIL ignore_result: got v%0b d%0d p%0d want v1 d%0d p%0d", result_valid, digit, pattern, e[5:2], e[1:0]); end
      handshake();
   endtask

   task automatic test_timeout();
      logic [5:0] e;
      int n;
      int p0;
      p0 = to_pulses;
      drive_rolls(3'b001, 5, 0, 0);
      for (int i = 1; i < TO; i++) tick();
      n_checks++; if (timed_out !== 1'b0 || to_pulses != p0) begin
         n_fail++; $display("FAIL timeout_early: got pulses %0d want 0", to_pulses - p0); end
      tick();
      n_checks++; if (timed_out !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got %0b want 1", timed_out); end
      n_checks++; if (pattern !== 2'd3 || result_valid !== 1'b0 || round_count !== 8'(exp_round)) begin
         n_fail++; $display("FAIL timeout_effect: got p%0d v%0b r%0d want p3 v0 r%0d", pattern, result_valid, round_count, exp_round); end
      tick();
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL timeout_width: got %0b want 0", timed_out); end
      // Completing roll on the cycle the timer expires wins
      p0 = to_pulses;
      drive_rolls(3'b001, 1, 0, 0);
      drive_rolls(3'b010, 0, 2, 0);
      for (int i = 2; i < TO; i++) tick();
      drive_rolls(3'b100, 0, 0, 1);
      model_round(1, 2, 1);
      wait_valid(n);
      e = exp_q.pop_front();
      n_checks++; if (result_valid !== 1'b1 || {digit, pattern} !== e) begin
         n_fail++; $display("FAIL timeout_boundary: got v%0b d%0d p%0d want v1 d%0d p%0d", result_valid, digit, pattern, e[5:2], e[1:0]); end
      n_checks++; if (to_pulses != p0) begin n_fail++; $display("FAIL timeout_boundary_pulse: got %0d want 0", to_pulses - p0); end
      handshake();
   endtask

   task automatic test_hold();
      logic [5:0] e;
      int n;
      drive_rolls(3'b111, 5, 5, 5);
      model_round(5, 5, 5);
      wait_valid(n);
      e = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         drive_rolls(3'b111, 1 + i % 6, 2, 3);
         n_checks++; if (result_valid !== 1'b1 || {digit, pattern} !== e) begin
            n_fail++; $display("FAIL hold_%0d: got v%0b d%0d p%0d want v1 d%0d p%0d", i, result_valid, digit, pattern, e[5:2], e[1:0]); end
      end
      handshake();
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %0b want 0", result_valid); end
      drive_rolls(3'b011, 4, 6, 0);
      tick();
      tick();
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL hold_clean: got %0b want 0", result_valid); end
      drive_rolls(3'b100, 0, 0, 4);
      model_round(4, 6, 4);
      wait_valid(n);
      e = exp_q.pop_front();
      n_checks++; if ({digit, pattern} !== e) begin
         n_fail++; $display("FAIL hold_next: got d%0d p%0d want d%0d p%0d", digit, pattern, e[5:2], e[1:0]); end
      handshake();
   endtask

   task automatic test_back_to_back();
      int nv;
      result_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         int a, b, c;
         a = $urandom_range(1, MF); b = $urandom_range(1, MF); c = $urandom_range(1, MF);
         drive_rolls(3'b111, a, b, c);
         model_round(a, b, c);
         void'(exp_q.pop_front());
         nv = 0;
         for (int i = 0; i < 4; i++) begin
            if (result_valid === 1'b1) nv++;
            tick();
         end
         n_checks++; if (nv != 1) begin n_fail++; $display("FAIL b2b_valid_cycles_%0d: got %0d want 1", r, nv); end
      end
      result_ready = 1'b0;
      n_checks++; if (round_count !== 8'(exp_round)) begin
         n_fail++; $display("FAIL b2b_rounds: got %0d want %0d", round_count, exp_round); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 30; r++) begin
         int f[3];
         int sched[3];
         int n, dly;
         logic [5:0] e;
         for (int p = 0; p < NP; p++) begin
            f[p] = $urandom_range(1, MF);
            sched[p] = $urandom_range(0, 4);
         end
         if ($urandom_range(0, 3) == 0) begin f[1] = f[0]; f[2] = f[0]; end
         for (int cyc = 0; cyc < 5; cyc++) begin
            logic [NP-1:0] m;
            int v[3];
            m = '0;
            for (int p = 0; p < NP; p++) begin
               v[p] = 0;
               if (cyc == sched[p]) begin m[p] = 1'b1; v[p] = f[p]; end
               else if (cyc < sched[p] && $urandom_range(0, 2) == 0) begin
                  m[p] = 1'b1; v[p] = ($urandom_range(0, 1) == 0) ? 0 : 7; end
               else if (cyc > sched[p] && $urandom_range(0, 2) == 0) begin
                  m[p] = 1'b1; v[p] = $urandom_range(1, MF); end
            end
            drive_rolls(m, v[0], v[1], v[2]);
         end
         model_round(f[0], f[1], f[2]);
         wait_valid(n);
         dly = $urandom_range(0, 3);
         for (int i = 0; i < dly; i++) tick();
         n_checks++;
         if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_%0d: expected queue empty", r); end
         else begin
            e = exp_q.pop_front();
            if (result_valid !== 1'b1 || {digit, pattern} !== e || round_count !== 8'(exp_round) ||
                pasch_count !== 8'(exp_pasch)) begin
               n_fail++;
               $display("FAIL rnd_%0d: got v%0b d%0d p%0d r%0d c%0d want v1 d%0d p%0d r%0d c%0d", r, result_valid,
                        digit, pattern, round_count, pasch_count, e[5:2], e[1:0], exp_round, exp_pasch);
            end
         end
         handshake();
      end
   endtask

   task automatic test_clear();
      int n;
      drive_rolls(3'b111, 6, 6, 6);
      model_round(6, 6, 6);
      wait_valid(n);
      void'(exp_q.pop_front());
      handshake();
      drive_rolls(3'b011, 1, 2, 0);
      clear = 1'b1;
      drive_rolls(3'b100, 0, 0, 4);
      clear = 1'b0;
      n_checks++; if (pattern !== 2'd3 || digit !== 4'd6 || timed_out !== 1'b0) begin
         n_fail++; $display("FAIL clear_collect: got p%0d d%0d t%0b want p3 d6 t0", pattern, digit, timed_out); end
      tick(); tick(); tick();
      n_checks++; if (result_valid !== 1'b0 || round_count !== 8'(exp_round)) begin
         n_fail++; $display("FAIL clear_no_result: got v%0b r%0d want v0 r%0d", result_valid, round_count, exp_round); end
      drive_rolls(3'b111, 2, 2, 2);
      model_round(2, 2, 2);
      wait_valid(n);
      void'(exp_q.pop_front());
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_checks++; if (result_valid !== 1'b0 || pattern !== 2'd3 || digit !== 4'd2) begin
         n_fail++; $display("FAIL clear_result: got v%0b p%0d d%0d want v0 p3 d2", result_valid, pattern, digit); end
      n_checks++; if (round_count !== 8'(exp_round)) begin
         n_fail++; $display("FAIL clear_rounds: got %0d want %0d", round_count, exp_round); end
   endtask

   task automatic test_reset_mid();
      int n;
      logic [5:0] e;
      drive_rolls(3'b111, 3, 3, 3);
      model_round(3, 3, 3);
      wait_valid(n);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (result_valid !== 1'b0 || digit !== 4'd0 || pattern !== 2'd3 || round_count !== 8'd0 ||
                      pasch_count !== 8'd0 || timed_out !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid: got v%0b d%0d p%0d r%0d c%0d want v0 d0 p3 r0 c0", result_valid, digit,
                            pattern, round_count, pasch_count); end
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();
      drive_rolls(3'b110, 0, 1, 2);
      tick(); tick();
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_clean: got %0b want 0", result_valid); end
      drive_rolls(3'b001, 5, 0, 0);
      model_round(5, 1, 2);
      wait_valid(n);
      e = exp_q.pop_front();
      n_checks++; if (result_valid !== 1'b1 || {digit, pattern} !== e || round_count !== 8'd1) begin
         n_fail++; $display("FAIL reset_after: got v%0b d%0d p%0d r%0d want v1 d%0d p%0d r1", result_valid, digit, pattern,
                            round_count, e[5:2], e[1:0]); end
      handshake();
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_pasch();
      test_classes();
      test_ignore();
      test_timeout();
      test_hold();
      test_back_to_back();
      test_random();
      test_clear();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
